stopwatch_core: RTL and testbench

MM:SS stopwatch with run/stop, split (lap-hold) and clear, driven by two button inputs that are already debounced. It divides the system clock down to a 1 s tick, counts 00:00–59:59 in BCD and drives four 7-segment digits plus run and hold status indicators. It sits between the board button and debounce logic and the display pins.

---
 rtl/stopwatch_core.sv | 132 +++++++++++++
 tb/tb_stopwatch_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with run/stop, split-hold and clear, driving four 7-segment digits.
// Button edge acts on the next clk edge; count updates one edge after the tick, display one edge later.
module stopwatch_core #(
    parameter int SPN = 24_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_run,
    input  logic       b_clr,
    output logic [6:0] sec_0,
    output logic [6:0] sec_1,
    output logic [6:0] min_0,
    output logic [6:0] min_1,
    output logic       s_run,
    output logic       s_hld
);

    localparam int              PW      = (SPN > 2) ? $clog2(SPN) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(SPN - 1);

    logic          r_b_run_d;
    logic          r_b_clr_d;
    logic          r_run;
    logic          r_hld;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_s0, r_s1, r_m0, r_m1;
    logic [3:0]    r_d0, r_d1, r_d2, r_d3;

    logic          w_run_ev;
    logic          w_clr_ev;
    logic          w_clr_stop;
    logic          w_tick;

    assign w_run_ev   = b_run & ~r_b_run_d;
    assign w_clr_ev   = b_clr & ~r_b_clr_d;
    assign w_clr_stop = w_clr_ev & ~r_run;
    assign w_tick     = r_run && (r_pre == PRE_MAX);

    // Clear/split decisions use the pre-toggle run state, so a same-cycle run event does not affect them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_b_run_d <= 1'b0;
            r_b_clr_d <= 1'b0;
            r_run     <= 1'b0;
            r_hld     <= 1'b0;
        end else begin
            r_b_run_d <= b_run;
            r_b_clr_d <= b_clr;
            if (w_run_ev) begin
                r_run <= ~r_run;
            end
            if (w_clr_ev) begin
                r_hld <= r_run ? ~r_hld : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_clr_stop) begin
            r_pre <= '0;
        end else if (r_run) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_clr_stop) begin
            r_s0 <= 4'd0;
            r_s1 <= 4'd0;
            r_m0 <= 4'd0;
            r_m1 <= 4'd0;
        end else if (w_tick) begin
            if (r_s0 == 4'd9) begin
                r_s0 <= 4'd0;
                if (r_s1 == 4'd5) begin
                    r_s1 <= 4'd0;
                    if (r_m0 == 4'd9) begin
                        r_m0 <= 4'd0;
                        r_m1 <= (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
                    end else begin
                        r_m0 <= r_m0 + 4'd1;
                    end
                end else begin
                    r_s1 <= r_s1 + 4'd1;
                end
            end else begin
                r_s0 <= r_s0 + 4'd1;
            end
        end
    end

    // Display tracks the live count unless a split is holding it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_d0 <= 4'd0;
            r_d1 <= 4'd0;
            r_d2 <= 4'd0;
            r_d3 <= 4'd0;
        end else if (!r_hld) begin
            r_d0 <= r_s0;
            r_d1 <= r_s1;
            r_d2 <= r_m0;
            r_d3 <= r_m1;
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    assign sec_0 = f_seg(r_d0);
    assign sec_1 = f_seg(r_d1);
    assign min_0 = f_seg(r_d2);
    assign min_1 = f_seg(r_d3);
    assign s_run = r_run;
    assign s_hld = r_hld;

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch bench: elapsed-seconds reference model checked every cycle, plus fixed-point literal checks.
module tb_stopwatch_core;

    localparam int SPN = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_run = 1'b0;
    logic       b_clr = 1'b0;
    logic [6:0] sec_0, sec_1, min_0, min_1;
    logic       s_run, s_hld;

    stopwatch_core #(.SPN(SPN)) dut (
        .clk  (clk),
        .rst  (rst),
        .b_run(b_run),
        .b_clr(b_clr),
        .sec_0(sec_0),
        .sec_1(sec_1),
        .min_0(min_0),
        .min_1(min_1),
        .s_run(s_run),
        .s_hld(s_hld)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state: elapsed time as plain seconds, display as frozen seconds value.
    int m_secs, m_pre, m_disp;
    bit m_run, m_hld, m_brd, m_bcd;
    bit m_valid = 1'b0;
    bit done = 1'b0;

    function automatic logic [27:0] segs_of(input int t);
        return {seg_tab[t / 600], seg_tab[(t / 60) % 10], seg_tab[(t % 60) / 10], seg_tab[t % 10]};
    endfunction

    task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rev, cev, tick;
        int n_secs, n_pre, n_disp;
        bit n_run, n_hld;
        if (!rst) begin
            m_secs = 0; m_pre = 0; m_disp = 0;
            m_run = 0; m_hld = 0; m_brd = 0; m_bcd = 0;
            m_valid = 1'b1;
        end else begin
            rev    = b_run && !m_brd;
            cev    = b_clr && !m_bcd;
            tick   = m_run && (m_pre == SPN - 1);
            n_disp = m_hld ? m_disp : m_secs;
            n_secs = m_secs;
            n_pre  = m_pre;
            n_run  = m_run;
            n_hld  = m_hld;
            if (m_run) begin
                n_pre = (m_pre + 1) % SPN;
                if (tick) n_secs = (m_secs + 1) % 3600;
            end
            if (cev) begin
                if (!m_run) begin
                    n_secs = 0; n_pre = 0; n_hld = 0;
                end else begin
                    n_hld = !m_hld;
                end
            end
            if (rev) n_run = !m_run;
            m_secs = n_secs; m_pre = n_pre; m_disp = n_disp;
            m_run = n_run; m_hld = n_hld;
            m_brd = b_run; m_bcd = b_clr;
        end
    end

    always @(negedge clk) begin
        if (m_valid && !done)
            check("model", {min_1, min_0, sec_1, sec_0, s_run, s_hld},
                  {segs_of(m_disp), m_run, m_hld});
    end

    task automatic press(input bit clr, input int n);
        if (clr) b_clr = 1'b1; else b_run = 1'b1;
        repeat (n) @(negedge clk);
        b_run = 1'b0;
        b_clr = 1'b0;
    endtask

    task automatic lit(input string name, input logic [27:0] exp_seg, input bit exp_run, input bit exp_hld);
        check(name, {min_1, min_0, sec_1, sec_0, s_run, s_hld}, {exp_seg, exp_run, exp_hld});
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        lit("reset", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0, 1'b0);
        rst = 1'b1;

        press(1'b0, 10);
        lit("run_once", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 1'b0);

        repeat (31 * SPN) @(negedge clk);
        lit("t_00_31", {7'h3F, 7'h3F, 7'h4F, 7'h06}, 1'b1, 1'b0);

        press(1'b1, 3);
        repeat (13 * SPN) @(negedge clk);
        lit("split_hold", {7'h3F, 7'h3F, 7'h4F, 7'h06}, 1'b1, 1'b1);

        press(1'b1, 3);
        lit("split_rel", {7'h3F, 7'h3F, 7'h66, 7'h66}, 1'b1, 1'b0);

        repeat (7 * SPN) @(negedge clk);
        lit("t_00_51", {7'h3F, 7'h3F, 7'h6D, 7'h06}, 1'b1, 1'b0);

        press(1'b0, 3);
        repeat (7 * SPN) @(negedge clk);
        lit("stopped", {7'h3F, 7'h3F, 7'h6D, 7'h06}, 1'b0, 1'b0);

        press(1'b1, 3);
        lit("cleared", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0, 1'b0);

        press(1'b0, 3);
        repeat (793 * SPN) @(negedge clk);
        lit("t_13_13", {7'h06, 7'h4F, 7'h06, 7'h4F}, 1'b1, 1'b0);

        repeat (2806 * SPN) @(negedge clk);
        lit("t_59_59", {7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1'b1, 1'b0);

        repeat (SPN) @(negedge clk);
        lit("wrap", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 1'b0);

        // Stop with 3 prescaler counts consumed; after restart only 17 cycles remain to the tick.
        press(1'b0, 3);
        repeat (5) @(negedge clk);
        press(1'b0, 3);
        repeat (15) @(negedge clk);
        lit("partial_pre", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 1'b0);
        @(negedge clk);
        lit("partial_tick", {7'h3F, 7'h3F, 7'h3F, 7'h06}, 1'b1, 1'b0);

        rst = 1'b0;
        @(negedge clk);
        lit("mid_reset", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 400; i++) begin
            b_run = ($urandom_range(0, 2) == 0);
            b_clr = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 60) != 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            rst = 1'b1;
        end
        b_run = 1'b0;
        b_clr = 1'b0;
        repeat (3) @(negedge clk);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
